// File: rtl/dram_prefetch_fifo_pkg.sv
// Shared definitions for the DRAM prefetch FIFO: FSM encodings and statistics helpers.
package dram_prefetch_fifo_pkg;

  localparam logic [1:0] StIdle   = 2'h0;
  localparam logic [1:0] StFill   = 2'h1;
  localparam logic [1:0] StStream = 2'h2;
  localparam logic [1:0] StFlush  = 2'h3;

  localparam int unsigned StatsWidth = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [StatsWidth-1:0] sat_inc(input logic [StatsWidth-1:0] v);
    return (&v) ? v : v + StatsWidth'(1);
  endfunction

endpackage

// File: rtl/prefetch_fifo_ram.sv
// DEPTH x WIDTH storage for the prefetch FIFO: synchronous write, asynchronous read.
module prefetch_fifo_ram
  import dram_prefetch_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ABITS = 2
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dram_prefetch_fifo.sv
// DRAM stream prefetcher: keeps a DEPTH-word FWFT FIFO topped up with single-cycle read requests.
// Optional statistics outputs are built when DRAM_PREFETCH_STATS_EN is defined.
module dram_prefetch_fifo
  import dram_prefetch_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ABITS  = 2,
  parameter int unsigned THRESH = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic             dram_ready,
  output logic             dram_request,
  input  logic [WIDTH-1:0] dram_data,
  input  logic             data_sent,
  output logic [WIDTH-1:0] fetched_data,
  output logic             fetched_valid,
  output logic [ABITS:0]   level_o
`ifdef DRAM_PREFETCH_STATS_EN
  ,
  output logic [15:0]      underrun_count,
  output logic [15:0]      stall_count
`endif
);

  localparam logic [ABITS:0]   ThreshW = THRESH[ABITS:0];
  localparam logic [ABITS+1:0] DepthW  = DEPTH[ABITS+1:0];

  logic [1:0]       state_q, state_d;
  logic [ABITS:0]   level_q, level_d, outst_q, outst_d;
  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d, ram_rdata;
  logic             valid_q, valid_d, req_q, req_d;
  logic             ready_ok, wr_en, pop;
  logic [ABITS+1:0] committed;

  always_comb begin
    // A ready pulse with nothing outstanding is a stray word and is ignored entirely.
    ready_ok = dram_ready && (outst_q != '0);
    wr_en    = ready_ok && !flush_i && (state_q != StFlush);
    pop      = data_sent && valid_q;
    outst_d  = outst_q + (ABITS+1)'(req_q) - (ABITS+1)'(ready_ok);

    if (flush_i) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      level_d  = level_q + (ABITS+1)'(wr_en) - (ABITS+1)'(pop);
      wr_ptr_d = wr_ptr_q + ABITS'(wr_en);
      rd_ptr_d = rd_ptr_q + ABITS'(pop);
    end

    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable_i) state_d = (level_d < ThreshW) ? StFill : StStream;
      StFill:   if (level_d >= ThreshW) state_d = StStream;
      StStream: if (!enable_i) state_d = StIdle;
      StFlush:  if (outst_d == '0) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (flush_i) state_d = StFlush;

    committed = {1'b0, level_d} + {1'b0, outst_d};
    req_d     = ((state_d == StFill) || (state_d == StStream)) && (committed < DepthW) && !req_q;
    valid_d   = ((state_d == StStream) || (state_d == StIdle)) && (level_d != '0);

    // Bypass a word landing in the slot that becomes the head this cycle.
    head_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? dram_data : ram_rdata;
  end

  prefetch_fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .ABITS(ABITS)
  ) u_ram (
    .clock_i(clock_i),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(dram_data),
    .raddr_i(rd_ptr_d),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      level_q  <= '0;
      outst_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      outst_q  <= outst_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
    end
  end

  assign dram_request  = req_q;
  assign fetched_data  = head_q;
  assign fetched_valid = valid_q;
  assign level_o       = level_q;

`ifdef DRAM_PREFETCH_STATS_EN
  logic [StatsWidth-1:0] underrun_q, stall_q;

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      underrun_q <= '0;
      stall_q    <= '0;
    end else begin
      if (data_sent && !valid_q) underrun_q <= sat_inc(underrun_q);
      if ((state_q == StStream) && (level_q == '0)) stall_q <= sat_inc(stall_q);
    end
  end

  assign underrun_count = underrun_q;
  assign stall_count    = stall_q;
`endif

`ifdef __icarus
  always_ff @(posedge clock_i) begin
    if (!reset_i && dram_ready && (outst_q == '0) && (state_q != StFlush))
      $error("dram_prefetch_fifo: dram_ready with no outstanding request");
  end
`endif

endmodule

// File: tb/tb_dram_prefetch_fifo.sv
// Scoreboard bench for dram_prefetch_fifo with a 3-cycle-latency DRAM model.
module tb_dram_prefetch_fifo;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1, enable_i = 1'b0, flush_i = 1'b0;
  logic        dram_ready = 1'b0, data_sent = 1'b0;
  logic        dram_request, fetched_valid;
  logic [23:0] dram_data = '0, fetched_data;
  logic [2:0]  level_o;
`ifdef DRAM_PREFETCH_STATS_EN
  logic [15:0] underrun_count, stall_count;
`endif

  dram_prefetch_fifo #(
    .WIDTH(24), .DEPTH(4), .ABITS(2), .THRESH(2)
  ) dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .flush_i      (flush_i),
    .dram_ready   (dram_ready),
    .dram_request (dram_request),
    .dram_data    (dram_data),
    .data_sent    (data_sent),
    .fetched_data (fetched_data),
    .fetched_valid(fetched_valid),
    .level_o      (level_o)
`ifdef DRAM_PREFETCH_STATS_EN
    ,
    .underrun_count(underrun_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DRAM model, consumer and scoreboard state
  int          cyc = 0, word_ctr = 0, req_total = 0, inv_errs = 0, consumed = 0;
  int          due_q[$];
  bit          disc_q[$];
  logic [23:0] exp_q[$];
  bit          prev_req = 0;
  bit          consume_en = 0, force_sent = 0, sim_mode = 0, flush_req = 0;
  bit          rel_watch = 0;
  int          rel_pop_cyc = -1, rel_delay = -1;
  bit          sim_chk = 0;
  logic [23:0] sim_word = '0;
  int          sim_events = 0;

  always @(negedge clk) begin
    bit          will_ready;
    logic [23:0] w;
    cyc++;
    dram_ready = 1'b0;
    data_sent  = 1'b0;
    flush_i    = 1'b0;
    w          = '0;
    if (reset_i) begin
      prev_req = 0;
    end else begin
      if (sim_chk) begin
        check_eq("simul_level", 32'(level_o), 32'd1);
        check_eq("simul_head", 32'(fetched_data), 32'(sim_word));
        sim_chk = 0;
        sim_events++;
      end
      if (dram_request) begin
        req_total++;
        if (prev_req) inv_errs++;
        foreach (disc_q[i]) if (disc_q[i]) inv_errs++;
        due_q.push_back(cyc + 3);
        disc_q.push_back(1'b0);
        if (rel_watch && rel_pop_cyc >= 0 && rel_delay < 0) rel_delay = cyc - rel_pop_cyc;
      end
      prev_req = dram_request;
      if (int'(level_o) + due_q.size() > 4 || level_o > 3'd4) inv_errs++;
      will_ready = (due_q.size() > 0) && (due_q[0] == cyc);
      if (flush_req) begin
        flush_i = 1'b1;
        exp_q.delete();
        foreach (disc_q[i]) disc_q[i] = 1'b1;
        flush_req = 0;
      end
      if (will_ready) begin
        word_ctr++;
        w          = 24'(word_ctr);
        dram_ready = 1'b1;
        dram_data  = w;
        if (!disc_q[0]) exp_q.push_back(w);
        void'(due_q.pop_front());
        void'(disc_q.pop_front());
      end
      if (!flush_i && fetched_valid &&
          (consume_en || (sim_mode && (will_ready || level_o > 3'd1)))) begin
        data_sent = 1'b1;
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("sb_head", 32'(fetched_data), 32'(exp_q.pop_front()));
        if (sim_mode && will_ready && level_o == 3'd1) begin
          sim_chk  = 1;
          sim_word = w;
        end
        consumed++;
        if (rel_watch && rel_pop_cyc < 0) rel_pop_cyc = cyc;
      end
      if (force_sent) data_sent = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  drain_ctr;
    bit  early_valid;
    reset_i = 1'b1;
    repeat (4) tick();
    check_eq("rst_request", 32'(dram_request), 32'd0);
    check_eq("rst_valid", 32'(fetched_valid), 32'd0);
    check_eq("rst_data", 32'(fetched_data), 32'd0);
    check_eq("rst_level", 32'(level_o), 32'd0);
    reset_i = 1'b0;

    // Priming
    enable_i = 1'b1;
    early_valid = 0;
    for (int i = 0; i < 60 && !fetched_valid; i++) begin
      if (level_o >= 3'd2) early_valid = 1;
      tick();
    end
    check_eq("prime_valid", 32'(fetched_valid), 32'd1);
    check_eq("prime_level", 32'(level_o), 32'd2);
    check_eq("prime_head", 32'(fetched_data), 32'h000001);
    check_eq("prime_held_low", 32'(early_valid), 32'd0);

    // Backpressure
    for (int i = 0; i < 60 && level_o != 3'd4; i++) tick();
    repeat (12) tick();
    check_eq("bp_level", 32'(level_o), 32'd4);
    check_eq("bp_requests", 32'(req_total), 32'd4);
    rel_watch  = 1;
    consume_en = 1;

    // Full-rate stream
    for (int i = 0; i < 600 && consumed < 64; i++) tick();
    check_eq("bp_rereq", 32'(rel_delay >= 1 && rel_delay <= 2), 32'd1);
    check_eq("stream_count", 32'(consumed >= 64), 32'd1);
    check_eq("invariants", 32'(inv_errs), 32'd0);

    // Simultaneous ready and pop at level 1
    consume_en = 0;
    sim_mode   = 1;
    for (int i = 0; i < 200 && sim_events < 3; i++) tick();
    sim_mode = 0;
    check_eq("simul_events", 32'(sim_events >= 3), 32'd1);

    // Flush with words buffered and in flight
    for (int i = 0; i < 60 && !(level_o >= 3'd2 && due_q.size() >= 1); i++) tick();
    check_eq("flush_setup_inflight", 32'(due_q.size() >= 1), 32'd1);
    flush_req = 1;
    tick();
    check_eq("flush_valid", 32'(fetched_valid), 32'd0);
    check_eq("flush_level", 32'(level_o), 32'd0);
    for (int i = 0; i < 40 && due_q.size() != 0; i++) tick();
    drain_ctr = word_ctr;
    tick();
    check_eq("flush_late_level", 32'(level_o), 32'd0);
    for (int i = 0; i < 60 && !fetched_valid; i++) tick();
    check_eq("refill_valid", 32'(fetched_valid), 32'd1);
    check_eq("refill_level", 32'(level_o), 32'd2);
    check_eq("refill_head", 32'(fetched_data), 32'(drain_ctr + 1));

    // Drain with enable low
    enable_i   = 1'b0;
    consume_en = 1;
    for (int i = 0; i < 80 && (level_o != 3'd0 || due_q.size() != 0 || fetched_valid); i++) tick();
    consume_en = 0;
    repeat (4) tick();
    check_eq("drain_level", 32'(level_o), 32'd0);
    check_eq("drain_request", 32'(dram_request), 32'd0);
    check_eq("invariants_end", 32'(inv_errs), 32'd0);

`ifdef DRAM_PREFETCH_STATS_EN
    flush_req = 1;
    repeat (2) tick();
    force_sent = 1;
    repeat (5) tick();
    force_sent = 0;
    tick();
    check_eq("stats_underrun", 32'(underrun_count), 32'd5);
    check_eq("stats_stall_idle", 32'(stall_count), 32'd0);
    flush_req = 1;
    repeat (2) tick();
    check_eq("stats_flush_clear", 32'(underrun_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
